// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan controller.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StShow
    } scan_state_e;

    // Segments a..g in bits 0..6, active-high; index is the hex nibble.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment pattern decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scanner with shadow/active digit registers.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_ZERO_BLANK_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned BLANK    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       commit,
    output logic [6:0] seg,
    output logic [3:0] dig_en,
    output logic       commit_pend,
    output logic       frame_done
);

    localparam int unsigned CntMax = (PRESCALE > BLANK) ? PRESCALE : BLANK;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    scan_state_e     state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      shadow_q [NUM_DIGITS];
    logic [3:0]      shadow_byp [NUM_DIGITS];
    logic [3:0]      active_q [NUM_DIGITS];
    logic [3:0]      active_d [NUM_DIGITS];
    logic            commit_pend_q, commit_pend_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      dig_en_q, dig_en_d;
    logic            frame_done_q, frame_done_d;

    logic            last;
    logic            boundary;
    logic            do_copy;
    logic            lz;
    logic [3:0]      dec_hex;
    logic [6:0]      dec_seg;

    assign last     = (cnt_q == CntW'(1));
    assign boundary = (state_q == StShow) && last && (idx_q == 2'd3);
    assign do_copy  = boundary && (commit_pend_q || commit);

    // Next-state: scan sequencing, commit tracking and the boundary copy.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        commit_pend_d = commit_pend_q;
        shadow_byp    = shadow_q;
        active_d      = active_q;

        unique case (state_q)
            StIdle: begin
                idx_d = 2'd0;
                cnt_d = '0;
                if (en) begin
                    state_d = StBlank;
                    cnt_d   = CntW'(BLANK);
                end
            end
            StBlank: begin
                if (last) begin
                    state_d = StShow;
                    cnt_d   = CntW'(PRESCALE);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StShow: begin
                if (last) begin
                    state_d = StBlank;
                    cnt_d   = CntW'(BLANK);
                    idx_d   = idx_q + 2'd1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (!en) begin
            state_d = StIdle;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end

        // A write landing in the boundary cycle is folded into the copy.
        if (wr_en) begin
            shadow_byp[wr_addr] = wr_data;
        end

        if (do_copy) begin
            active_d      = shadow_byp;
            commit_pend_d = 1'b0;
        end else if (commit) begin
            commit_pend_d = 1'b1;
        end
    end

    assign dec_hex = active_d[idx_d];

    seg7_hex_decode u_hex_decode (
        .hex (dec_hex),
        .seg (dec_seg)
    );

    // Outputs are derived from the next state so the registered values line up with it.
    always_comb begin
        dig_en_d     = 4'b0000;
        seg_d        = 7'h00;
        frame_done_d = 1'b0;
        lz           = 1'b0;
`ifdef SEG7_SCAN_ZERO_BLANK_EN
        lz = (idx_d != 2'd0);
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx_d) && active_d[i] != 4'd0) begin
                lz = 1'b0;
            end
        end
`endif
        if (state_d == StShow) begin
            dig_en_d     = 4'b0001 << idx_d;
            seg_d        = lz ? 7'h00 : dec_seg;
            frame_done_d = (cnt_d == CntW'(1)) && (idx_d == 2'd3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            idx_q         <= 2'd0;
            cnt_q         <= '0;
            shadow_q      <= '{default: 4'd0};
            active_q      <= '{default: 4'd0};
            commit_pend_q <= 1'b0;
            seg_q         <= 7'h00;
            dig_en_q      <= 4'b0000;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            active_q      <= active_d;
            commit_pend_q <= commit_pend_d;
            seg_q         <= seg_d;
            dig_en_q      <= dig_en_d;
            frame_done_q  <= frame_done_d;
            if (wr_en) begin
                shadow_q[wr_addr] <= wr_data;
            end
        end
    end

    assign seg         = seg_q;
    assign dig_en      = dig_en_q;
    assign commit_pend = commit_pend_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with PRESCALE=4, BLANK=2 (24-cycle frame).
module tb_seg7_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       commit;
    logic [6:0] seg;
    logic [3:0] dig_en;
    logic       commit_pend;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;

    seg7_scan_ctrl #(
        .PRESCALE (4),
        .BLANK    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .seg         (seg),
        .dig_en      (dig_en),
        .commit_pend (commit_pend),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // act holds digit 0 in bits [3:0] through digit 3 in bits [15:12].
    function automatic logic [6:0] exp_seg(input logic [15:0] act, input int d);
        logic [3:0] nib;
        nib = act[4*d +: 4];
`ifdef SEG7_SCAN_ZERO_BLANK_EN
        if (d != 0) begin
            logic all_zero;
            all_zero = 1'b1;
            for (int i = d; i < 4; i++) begin
                if (act[4*i +: 4] != 4'd0) all_zero = 1'b0;
            end
            if (all_zero) return 7'h00;
        end
`endif
        return hex7(nib);
    endfunction

    // Checks a full 24-cycle frame starting at the first BLANK cycle of digit 0.
    task automatic run_frame(input logic [15:0] act);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 6; c++) begin
                if (c < 2) begin
                    check($sformatf("blank_d%0d_c%0d_dig", d, c), 32'(dig_en), 32'h0);
                    check($sformatf("blank_d%0d_c%0d_seg", d, c), 32'(seg), 32'h0);
                end else begin
                    check($sformatf("show_d%0d_c%0d_dig", d, c), 32'(dig_en), 32'(4'b0001 << d));
                    check($sformatf("show_d%0d_c%0d_seg", d, c), 32'(seg), 32'(exp_seg(act, d)));
                end
                check($sformatf("fd_d%0d_c%0d", d, c), 32'(frame_done),
                      32'((d == 3 && c == 5) ? 1 : 0));
                step();
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = 4'd0;
        commit  = 1'b0;
        step();
        step();
        check("rst_dig", 32'(dig_en), 32'h0);
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_pend", 32'(commit_pend), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);

        // Release with en high: BLANK begins on the first edge.
        en    = 1'b1;
        rst_n = 1'b1;
        step();
        run_frame(16'h0000);

        // Shadow writes are invisible until the commit lands at the frame boundary.
        fork
            run_frame(16'h0000);
            begin
                for (int a = 0; a < 4; a++) begin
                    wr_en   = 1'b1;
                    wr_addr = a[1:0];
                    wr_data = 4'(a + 1);
                    step();
                end
                wr_en  = 1'b0;
                commit = 1'b1;
                step();
                commit = 1'b0;
                check("pend_set", 32'(commit_pend), 32'h1);
                repeat (18) step();
                check("pend_hold_fd", 32'(commit_pend), 32'h1);
                check("fd_at_boundary", 32'(frame_done), 32'h1);
                step();
                check("pend_clr", 32'(commit_pend), 32'h0);
            end
        join
        run_frame(16'h4321);

        // Write in the boundary cycle is bypassed into the copy.
        fork
            run_frame(16'h4321);
            begin
                step();
                step();
                commit = 1'b1;
                step();
                commit = 1'b0;
                check("pend_set2", 32'(commit_pend), 32'h1);
                repeat (20) step();
                wr_en   = 1'b1;
                wr_addr = 2'd0;
                wr_data = 4'd8;
                step();
                wr_en = 1'b0;
                check("pend_clr2", 32'(commit_pend), 32'h0);
            end
        join
        run_frame(16'h4328);

        // Drop en during digit 2 SHOW, then restart.
        repeat (15) step();
        check("d2_show_dig", 32'(dig_en), 32'h4);
        check("d2_show_seg", 32'(seg), 32'h4F);
        en = 1'b0;
        step();
        check("idle_dig", 32'(dig_en), 32'h0);
        check("idle_seg", 32'(seg), 32'h0);
        check("idle_fd", 32'(frame_done), 32'h0);
        repeat (3) step();
        check("idle_dig_hold", 32'(dig_en), 32'h0);
        en = 1'b1;
        step();
        run_frame(16'h4328);

        // Asynchronous reset in the middle of SHOW.
        repeat (3) step();
        check("pre_rst_dig", 32'(dig_en), 32'h1);
        check("pre_rst_seg", 32'(seg), 32'h7F);
        rst_n = 1'b0;
        #1;
        check("async_rst_dig", 32'(dig_en), 32'h0);
        check("async_rst_seg", 32'(seg), 32'h0);
        check("async_rst_pend", 32'(commit_pend), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Commit coinciding with the boundary copies at once and leaves commit_pend low.
        fork
            run_frame(16'h0000);
            begin
                wr_en   = 1'b1;
                wr_addr = 2'd0;
                wr_data = 4'd5;
                step();
                wr_en = 1'b0;
                repeat (22) step();
                commit = 1'b1;
                step();
                commit = 1'b0;
                check("coincide_pend", 32'(commit_pend), 32'h0);
            end
        join
        run_frame(16'h0005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 1000, clk cycles each digit is shown (>=2).
REQ-002 SHALL have parameter BLANK, default 4, clk cycles all digits are off between digits (>=1).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  scan enable.
REQ-006 SHALL have port wr_en  input  1  write strobe into the shadow digit registers.
REQ-007 SHALL have port wr_addr  input  2  shadow digit index, 0..3.
REQ-008 SHALL have port wr_data  input  4  hex nibble to store.
REQ-009 SHALL have port commit  input  1  single-cycle pulse requesting a shadow-to-active copy.
REQ-010 SHALL have port seg  output  7  segments a..g in bits 0..6, active-high.
REQ-011 SHALL have port dig_en  output  4  one-hot digit enable, active-high.
REQ-012 SHALL have port commit_pend  output  1  commit accepted but not yet applied.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-014 SHALL implement FSM states IDLE, BLANK and SHOW, with a 2-bit digit index idx and a down-counter wide enough for max(PRESCALE,BLANK).
REQ-015 SHALL, in IDLE, drive dig_en=0 and seg=0, hold idx=0, and enter BLANK with the counter loaded to BLANK on the first cycle en=1.
REQ-016 SHALL, in BLANK, drive dig_en=0 and seg=0 for exactly BLANK cycles, then enter SHOW loaded with PRESCALE.
REQ-017 SHALL, in SHOW, assert dig_en[idx] only and drive seg with the hex decode of active[idx] for exactly PRESCALE cycles, then enter BLANK with idx+1 mod 4.
REQ-018 SHALL treat the last SHOW cycle with idx=3 as the frame boundary: frame_done=1 for that cycle; wrap idx to 0.
REQ-019 SHALL, at the frame boundary with commit_pend=1, copy all four shadow registers to active and clear commit_pend on the next edge.
REQ-020 SHALL, for a wr_en in the frame-boundary cycle, include the written nibble in that copy (write bypass).
REQ-021 SHALL set commit_pend on commit=1; when commit and the boundary copy coincide, copy this frame and leave commit_pend=0.
REQ-022 SHALL write shadow[wr_addr]=wr_data on wr_en in any state, IDLE included; the active registers change only via commit.
REQ-023 SHALL, when en falls, enter IDLE on the next edge with dig_en=0, seg=0 and idx=0; commit_pend and all registers are retained; frame_done is not pulsed.
REQ-024 SHALL decode hex to segments with the standard 0-F patterns (0=0x3F, 1=0x06, 8=0x7F, A=0x77, F=0x71); all outputs registered.

Reset
REQ-025 SHALL, while rst_n=0, force state=IDLE, idx=0, counter=0, shadow and active=0, seg=0, dig_en=0, commit_pend=0 and frame_done=0.
REQ-026 SHALL, with en=1 at reset release, begin BLANK on the first edge after rst_n rises.

Configuration
REQ-027 SHALL, with SEG7_SCAN_ZERO_BLANK_EN defined, drive seg=0 during SHOW for any leading-zero digit; digit 3 is most significant and digit 0 always displays.
REQ-028 SHALL, without SEG7_SCAN_ZERO_BLANK_EN, display every digit including zeros.

Structure
REQ-029 SHALL hold the state enum, NUM_DIGITS=4 and the 16-entry segment table in package seg7_pkg.
REQ-030 SHALL contain exactly one sub-module, seg7_hex_decode (4-bit in, 7-bit out, combinational).

Verification (PRESCALE=4, BLANK=2, frame = 24 cycles)
REQ-031 SHALL cover: reset with en=1 -> 2 cycles dig_en=0, then dig_en=0001 with seg=0x3F for 4 cycles, then 2 cycles blank, then dig_en=0010.
REQ-032 SHALL cover: write digits 1,2,3,4 then commit mid-frame -> commit_pend=1 until the frame_done cycle, then the next frame shows 0x06,0x5B,0x4F,0x66 on digits 0..3.
REQ-033 SHALL cover: wr_en addr 0 data 8 in the frame_done cycle with commit_pend=1 -> digit 0 shows 0x7F in the next frame.
REQ-034 SHALL cover: en dropped during digit-2 SHOW -> next cycle dig_en=0, seg=0; en raised again -> restart at BLANK with digit 0.
REQ-035 SHALL cover: rst_n pulsed low mid-SHOW -> outputs zero immediately and asynchronously; active digits read 0 afterward.
REQ-036 SHALL cover: with SEG7_SCAN_ZERO_BLANK_EN and active = 0,0,0,5 (digit3..0) -> digits 3..1 seg=0 and digit 0 seg=0x6D; without the macro, digits 3..1 seg=0x3F.
